dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 200 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory behind a valid/ready request
// handshake and a valid/ready response handshake. Each accepted request
// waits LATENCY cycles, then performs its access on the edge that enters
// RESP. The response is held until the initiator consumes it.
// Optional feature macro: DMEM_RESP_ERR_CHECK_EN. When it is defined,
// misaligned or out-of-range addresses complete with resp_err_o=1 and never
// write memory. When it is undefined, addresses wrap modulo 4*DEPTH.
module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        busy_o
);
    localparam int         AW    = $clog2(DEPTH);
    localparam logic [3:0] LAT_V = 4'(LATENCY);
`ifdef DMEM_RESP_ERR_CHECK_EN
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [3:0]     cnt_r;
    logic [3:0]     cnt_next_s;
    logic           busy_r;
    logic           accept_s;
    logic           enter_resp_s;

    // Request fields captured at acceptance.
    logic           we_r;
    logic [AW-1:0]  idx_r;
    logic           err_r;
    logic [31:0]    wdata_r;

    // Decoded view of the live request inputs.
    logic [AW-1:0]  req_idx_s;
    logic           req_err_s;

    // Fields used by the access on the edge that enters RESP.
    logic           acc_we_s;
    logic [AW-1:0]  acc_idx_s;
    logic           acc_err_s;
    logic [31:0]    acc_wdata_s;

    logic [31:0]    mem_r [DEPTH];

    logic           resp_valid_r;
    logic [31:0]    resp_rdata_r;
    logic           resp_err_r;

    // Accept only from IDLE, and never while reset is asserted.
    assign req_ready_o  = ~busy_r & ~rst_i;
    assign busy_o       = busy_r;
    assign resp_valid_o = resp_valid_r;
    assign resp_rdata_o = resp_rdata_r;
    assign resp_err_o   = resp_err_r;

`ifndef DMEM_RESP_ERR_CHECK_EN
    // Byte-offset and upper address bits are deliberately ignored (wrap).
    logic unused_addr_s;
    assign unused_addr_s = ^{req_addr_i[31:AW+2], req_addr_i[1:0]};
`endif

    // Decode the incoming address into a word index and a legality flag.
    always_comb begin
        req_idx_s = req_addr_i[AW+1:2];
`ifdef DMEM_RESP_ERR_CHECK_EN
        req_err_s = (req_addr_i[1:0] != 2'd0) || (req_addr_i >= LIMIT);
`else
        req_err_s = 1'b0;
`endif
    end

    // Next-state logic. Counter loads LATENCY on acceptance and leaves WAIT on reaching 0.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        enter_resp_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid_i && !rst_i) begin
                    accept_s = 1'b1;
                    if (LAT_V == 4'd0) begin
                        state_next_s = RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_next_s = WAIT;
                        cnt_next_s   = LAT_V;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                cnt_next_s = cnt_r - 4'd1;
                if (cnt_r <= 4'd1) begin
                    state_next_s = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // A zero-latency access happens on the acceptance edge, so it uses the live inputs.
    always_comb begin
        if (state_r == IDLE) begin
            acc_we_s    = req_we_i;
            acc_idx_s   = req_idx_s;
            acc_err_s   = req_err_s;
            acc_wdata_s = req_wdata_i;
        end else begin
            acc_we_s    = we_r;
            acc_idx_s   = idx_r;
            acc_err_s   = err_r;
            acc_wdata_s = wdata_r;
        end
    end

    // State, wait counter and busy flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Capture the request on acceptance; later input changes are ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_r    <= 1'b0;
            idx_r   <= '0;
            err_r   <= 1'b0;
            wdata_r <= 32'd0;
        end else if (accept_s) begin
            we_r    <= req_we_i;
            idx_r   <= req_idx_s;
            err_r   <= req_err_s;
            wdata_r <= req_wdata_i;
        end
    end

    // Storage is not reset. A store commits only on a non-reset edge entering RESP.
    always_ff @(posedge clk_i) begin
        if (!rst_i && enter_resp_s && acc_we_s && !acc_err_s) begin
            mem_r[acc_idx_s] <= acc_wdata_s;
        end
    end

    // Response registers: load on entering RESP, clear on handshake or reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
        end else if (enter_resp_s) begin
            resp_valid_r <= 1'b1;
            resp_err_r   <= acc_err_s;
            resp_rdata_r <= (acc_we_s || acc_err_s) ? 32'd0 : mem_r[acc_idx_s];
        end else if ((state_r == RESP) && resp_ready_i) begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: drives two responders (LATENCY=2 and LATENCY=0) from
// shared inputs. A transaction-level model predicts every output on every
// cycle; directed scenarios add literal expectations.
module tb_dmem_responder;
    localparam int DEPTH = 32;
    localparam int NDUT  = 2;
`ifdef DMEM_RESP_ERR_CHECK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic req_valid_i = 1'b0;
    logic req_we_i = 1'b0;
    logic resp_ready_i = 1'b0;
    logic [31:0] req_addr_i = 32'd0;
    logic [31:0] req_wdata_i = 32'd0;

    logic [NDUT-1:0] rdy_w;
    logic [NDUT-1:0] vld_w;
    logic [NDUT-1:0] err_w;
    logic [NDUT-1:0] busy_w;
    logic [31:0]     rdata_w [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(rdy_w[0]),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(vld_w[0]), .resp_ready_i(resp_ready_i), .resp_rdata_o(rdata_w[0]),
        .resp_err_o(err_w[0]), .busy_o(busy_w[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(rdy_w[1]),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(vld_w[1]), .resp_ready_i(resp_ready_i), .resp_rdata_o(rdata_w[1]),
        .resp_err_o(err_w[1]), .busy_o(busy_w[1])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic logic [31:0] pre(input int i);
        return (i == 5) ? 32'h1234_5678 : (32'hC0DE_0000 + 32'(i));
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    // Inputs as seen at the most recent rising edge.
    logic s_rst = 1'b1, s_rvalid = 1'b0, s_we = 1'b0, s_rready = 1'b0;
    logic [31:0] s_addr = 32'd0, s_wdata = 32'd0;
    always @(posedge clk) begin
        s_rst    <= rst_i;
        s_rvalid <= req_valid_i;
        s_we     <= req_we_i;
        s_rready <= resp_ready_i;
        s_addr   <= req_addr_i;
        s_wdata  <= req_wdata_i;
    end

    // Transaction model: pending request with a due edge number, or a response on show.
    int          cyc = 0;
    bit          m_pend [NDUT];
    bit          m_resp [NDUT];
    int          m_due  [NDUT];
    bit          m_we   [NDUT];
    logic [31:0] m_addr [NDUT];
    logic [31:0] m_wdata[NDUT];
    logic [31:0] m_rdata[NDUT];
    bit          m_err  [NDUT];
    logic [31:0] m_mem  [NDUT][DEPTH];

    task automatic model_access(input int k);
        int idx;
        idx = int'((m_addr[k] >> 2) & 32'(DEPTH - 1));
        m_err[k] = ERRCHK && ((m_addr[k][1:0] != 2'd0) || (m_addr[k] >= 32'(4 * DEPTH)));
        if (m_we[k] && !m_err[k]) m_mem[k][idx] = m_wdata[k];
        m_rdata[k] = (m_we[k] || m_err[k]) ? 32'd0 : m_mem[k][idx];
        m_pend[k] = 1'b0;
        m_resp[k] = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            m_pend[k] = 1'b0;
            m_resp[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < NDUT; k++) begin
                if (s_rst) begin
                    m_pend[k] = 1'b0;
                    m_resp[k] = 1'b0;
                end else if (m_resp[k]) begin
                    if (s_rready) m_resp[k] = 1'b0;
                end else if (m_pend[k]) begin
                    if (cyc == m_due[k]) model_access(k);
                end else if (s_rvalid) begin
                    m_we[k]    = s_we;
                    m_addr[k]  = s_addr;
                    m_wdata[k] = s_wdata;
                    if (lat_of(k) == 0) model_access(k);
                    else begin
                        m_pend[k] = 1'b1;
                        m_due[k]  = cyc + lat_of(k);
                    end
                end
                check("resp_valid", k, 32'(vld_w[k]), 32'(m_resp[k]));
                check("resp_rdata", k, rdata_w[k], m_resp[k] ? m_rdata[k] : 32'd0);
                check("resp_err", k, 32'(err_w[k]), 32'(m_resp[k] && m_err[k]));
                check("busy", k, 32'(busy_w[k]), 32'(m_pend[k] || m_resp[k]));
                check("req_ready", k, 32'(rdy_w[k]), 32'(!(m_pend[k] || m_resp[k]) && !rst_i));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(rdy_w[0] && rdy_w[1]) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("wait_idle_timeout", 0, 32'(n), 32'd0);
    endtask

    // Present one request for exactly one edge, then scramble the request inputs.
    task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        wait_idle();
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        tick();
        req_valid_i = 1'b0;
        req_we_i    = ~we;
        req_addr_i  = $urandom;
        req_wdata_i = $urandom;
    endtask

    // Issue with resp_ready low, wait for both responses; lat0 counts cycles from acceptance.
    task automatic xact(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat0, output bit v1_next,
                        output logic [31:0] rd0, output logic [31:0] rd1,
                        output logic er0, output logic er1);
        int n;
        resp_ready_i = 1'b0;
        issue(we, addr, wdata);
        v1_next = vld_w[1];
        n = 1;
        while (!(vld_w[0] && vld_w[1]) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("resp_timeout", 0, 32'(n), 32'd0);
        lat0 = n;
        rd0  = rdata_w[0];
        rd1  = rdata_w[1];
        er0  = err_w[0];
        er1  = err_w[1];
    endtask

    task automatic handshake();
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
    endtask

    initial begin
        int lat0;
        bit v1;
        logic [31:0] rd0, rd1;
        logic er0, er1;
        int acc[$];
        int vs[$];
        logic [31:0] rds[$];

        // Reset state.
        repeat (3) tick();
        for (int k = 0; k < NDUT; k++) begin
            check("rst_ready", k, 32'(rdy_w[k]), 32'd0);
            check("rst_busy", k, 32'(busy_w[k]), 32'd0);
            check("rst_valid", k, 32'(vld_w[k]), 32'd0);
        end
        rst_i = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) check("ready_after_rst", k, 32'(rdy_w[k]), 32'd1);

        // Preload every word through stores.
        for (int i = 0; i < DEPTH; i++) begin
            xact(1'b1, 32'(i * 4), pre(i), lat0, v1, rd0, rd1, er0, er1);
            handshake();
        end

        // Back-to-back zero-latency loads of 0x0 then 0x4 with req_valid held high.
        resp_ready_i = 1'b1;
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_addr_i   = 32'h0;
        for (int i = 0; i < 6; i++) begin
            if (rdy_w[1]) acc.push_back(i);
            if (vld_w[1]) begin
                vs.push_back(i);
                rds.push_back(rdata_w[1]);
            end
            tick();
            if (i == 0) req_addr_i = 32'h4;
        end
        req_valid_i = 1'b0;
        wait_idle();
        resp_ready_i = 1'b0;
        check("b2b_count", 1, 32'(acc.size() >= 2 && vs.size() >= 2), 32'd1);
        check("b2b_acc_gap", 1, 32'(acc[1] - acc[0]), 32'd2);
        check("b2b_resp_lat", 1, 32'(vs[0] - acc[0]), 32'd1);
        check("b2b_rdata0", 1, rds[0], pre(0));
        check("b2b_rdata1", 1, rds[1], pre(1));

        // Store then load 0x10.
        xact(1'b1, 32'h10, 32'hDEAD_BEEF, lat0, v1, rd0, rd1, er0, er1);
        check("st_latency", 0, 32'(lat0), 32'd3);
        check("st_rdata", 0, rd0, 32'd0);
        check("st_lat0_resp", 1, 32'(v1), 32'd1);
        handshake();
        xact(1'b0, 32'h10, 32'd0, lat0, v1, rd0, rd1, er0, er1);
        check("ld_latency", 0, 32'(lat0), 32'd3);
        check("ld_rdata", 0, rd0, 32'hDEAD_BEEF);
        check("ld_rdata", 1, rd1, 32'hDEAD_BEEF);
        check("ld_err", 0, 32'(er0), 32'd0);
        check("model_word4", 0, m_mem[0][4], 32'hDEAD_BEEF);
        handshake();

        // Hold a load response for 5 cycles.
        xact(1'b0, 32'h14, 32'd0, lat0, v1, rd0, rd1, er0, er1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 0, 32'(vld_w[0]), 32'd1);
            check("hold_rdata", 0, rdata_w[0], 32'h1234_5678);
            check("hold_ready", 0, 32'(rdy_w[0]), 32'd0);
            check("hold_busy", 0, 32'(busy_w[0]), 32'd1);
        end
        handshake();

        // Reset while the store is waiting: no response, memory untouched.
        issue(1'b1, 32'h8, 32'hAAAA_5555);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rst_wait_valid", 0, 32'(vld_w[0]), 32'd0);
            check("rst_wait_busy", 0, 32'(busy_w[0]), 32'd0);
            tick();
        end
        xact(1'b0, 32'h8, 32'd0, lat0, v1, rd0, rd1, er0, er1);
        check("rst_discard_rdata", 0, rd0, pre(2));
        check("committed_rdata", 1, rd1, 32'hAAAA_5555);
        handshake();

`ifdef DMEM_RESP_ERR_CHECK_EN
        xact(1'b0, 32'h6, 32'd0, lat0, v1, rd0, rd1, er0, er1);
        check("misalign_err", 0, 32'(er0), 32'd1);
        check("misalign_rdata", 0, rd0, 32'd0);
        check("misalign_lat", 0, 32'(lat0), 32'd3);
        handshake();
        xact(1'b1, 32'h80, 32'hFFFF_FFFF, lat0, v1, rd0, rd1, er0, er1);
        check("range_err", 0, 32'(er0), 32'd1);
        check("range_err", 1, 32'(er1), 32'd1);
        handshake();
        xact(1'b0, 32'h0, 32'd0, lat0, v1, rd0, rd1, er0, er1);
        check("word0_kept", 0, rd0, pre(0));
        handshake();
`else
        xact(1'b1, 32'h84, 32'h1, lat0, v1, rd0, rd1, er0, er1);
        check("wrap_err", 0, 32'(er0), 32'd0);
        handshake();
        xact(1'b0, 32'h4, 32'd0, lat0, v1, rd0, rd1, er0, er1);
        check("wrap_rdata", 0, rd0, 32'h1);
        check("wrap_rdata", 1, rd1, 32'h1);
        handshake();
`endif

        // Random traffic, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst_i        = ($urandom_range(0, 99) == 0);
            req_valid_i  = ($urandom_range(0, 2) != 0);
            req_we_i     = 1'($urandom_range(0, 1));
            req_wdata_i  = $urandom;
            resp_ready_i = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 7));
            if (r == 0) req_addr_i = $urandom;
            else if (r == 1) req_addr_i = 32'($urandom_range(0, 4 * DEPTH - 1));
            else req_addr_i = 32'($urandom_range(0, DEPTH - 1)) << 2;
            tick();
        end
        rst_i        = 1'b0;
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b1;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
